fetch_pc: RTL and testbench

- Program-counter / fetch-sequencing stage directly downstream of the branch-offset LUT.
- Consumes the 4-bit LUT value together with decode's branch/jump qualifiers.
- Holds and advances the PC and drives the instruction-memory address.
- Runs the core's start/done handshake: idle until start, run until halt, then report done.

---
 rtl/core_pkg.sv | 14 +
 rtl/fetch_pc.sv | 103 ++++++++++
 tb/tb_fetch_pc.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types and helpers: fetch FSM states, default PC width and
// the 4-bit LUT offset sign extension (also used by the LUT verifier).
package core_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;

  localparam int PC_W_DEFAULT = 10;

  // Callers size-cast the 32-bit result down to their own PC width.
  function automatic logic [31:0] sext4(input logic [3:0] val);
    return {{28{val[3]}}, val};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter and fetch sequencing with start/halt/done handshake.
// Optional return-address register enabled by defining FETCH_PC_LINK_EN.
module fetch_pc
  import core_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic [3:0]      lut_val,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done
`ifdef FETCH_PC_LINK_EN
  ,
  output logic [PC_W-1:0] link_pc
`endif
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            start_q;
  logic            start_edge;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] pc_inc;

  assign start_edge = start & ~start_q;
  assign offset     = PC_W'(sext4(lut_val));
  assign pc_inc     = pc_q + PC_W'(1);

`ifdef FETCH_PC_LINK_EN
  logic [PC_W-1:0] link_q, link_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      start_q <= 1'b0;
`ifdef FETCH_PC_LINK_EN
      link_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= start;
`ifdef FETCH_PC_LINK_EN
      link_q  <= link_d;
`endif
    end
  end

  // Priority in RUN: restart, stall, halt, jump/branch (single add), step.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_PC_LINK_EN
    link_d  = link_q;
`endif
    case (state_q)
      IDLE, HALTED: begin
        if (start_edge) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
      RUN: begin
        if (start_edge) begin
          pc_d = START_PC;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt_req) begin
          state_d = HALTED;
        end else if (jump || branch_taken) begin
          pc_d = pc_q + offset;
`ifdef FETCH_PC_LINK_EN
          if (jump) link_d = pc_inc;
`endif
        end else begin
          pc_d = pc_inc;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  assign pc      = pc_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == HALTED);
`ifdef FETCH_PC_LINK_EN
  assign link_pc = link_q;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Directed self-checking bench for fetch_pc (PC_W=10, START_PC=0).
// Link-register checks are included when FETCH_PC_LINK_EN is defined.
module tb_fetch_pc;

  logic       clk = 1'b0;
  logic       reset, start, stall, halt_req, branch_taken, jump;
  logic [3:0] lut_val;
  logic [9:0] pc;
  logic       running, done;
`ifdef FETCH_PC_LINK_EN
  logic [9:0] link_pc;
`endif

  int compared   = 0;
  int mismatched = 0;

  fetch_pc #(.PC_W(10), .START_PC(10'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_taken(branch_taken), .jump(jump),
    .lut_val(lut_val), .pc(pc), .running(running), .done(done)
`ifdef FETCH_PC_LINK_EN
    , .link_pc(link_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCtrl();
    start = 0; stall = 0; halt_req = 0; branch_taken = 0; jump = 0; lut_val = 4'd0;
  endtask

  task automatic test_reset();
    clearCtrl();
    reset = 1; start = 1; jump = 1;
    tick(); tick();
    compared++;
    if ({running, done, pc} !== {1'b0, 1'b0, 10'd0}) begin
      mismatched++;
      $display("[TB] FAIL reset run=%b done=%b pc=%0d exp run=0 done=0 pc=0", running, done, pc);
    end
`ifdef FETCH_PC_LINK_EN
    compared++;
    if (link_pc !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL resetLink link_pc=%0d exp 0", link_pc);
    end
`endif
    reset = 0; clearCtrl();
    tick();
    compared++;
    if ({running, pc} !== {1'b0, 10'd0}) begin
      mismatched++;
      $display("[TB] FAIL idleHold run=%b pc=%0d exp run=0 pc=0", running, pc);
    end
  endtask

  task automatic test_start();
    start = 1;
    tick();
    compared++;
    if ({running, done, pc} !== {1'b1, 1'b0, 10'd0}) begin
      mismatched++;
      $display("[TB] FAIL startEdge run=%b done=%b pc=%0d exp run=1 done=0 pc=0", running, done, pc);
    end
    start = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      compared++;
      if (pc !== 10'(i)) begin
        mismatched++;
        $display("[TB] FAIL seqStep pc=%0d exp %0d", pc, i);
      end
    end
  endtask

  task automatic test_branch();
    tick(); tick();
    compared++;
    if (pc !== 10'd5) begin
      mismatched++;
      $display("[TB] FAIL reach5 pc=%0d exp 5", pc);
    end
    branch_taken = 1; lut_val = 4'b1101;
    tick();
    compared++;
    if (pc !== 10'd2) begin
      mismatched++;
      $display("[TB] FAIL branchNeg pc=%0d exp 2", pc);
    end
    clearCtrl();
    tick(); tick(); tick();
    jump = 1; lut_val = 4'b0111;
    tick();
    compared++;
    if (pc !== 10'd12) begin
      mismatched++;
      $display("[TB] FAIL jumpPos pc=%0d exp 12", pc);
    end
    branch_taken = 1; jump = 1; lut_val = 4'd3;
    tick();
    compared++;
    if (pc !== 10'd15) begin
      mismatched++;
      $display("[TB] FAIL jumpAndBranch pc=%0d exp 15", pc);
    end
    jump = 0; lut_val = 4'd0;
    tick();
    compared++;
    if (pc !== 10'd15) begin
      mismatched++;
      $display("[TB] FAIL selfLoop pc=%0d exp 15", pc);
    end
    clearCtrl();
  endtask

  task automatic test_stall();
    stall = 1; jump = 1; halt_req = 1; lut_val = 4'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({running, done, pc} !== {1'b1, 1'b0, 10'd15}) begin
        mismatched++;
        $display("[TB] FAIL stallHold run=%b done=%b pc=%0d exp run=1 done=0 pc=15", running, done, pc);
      end
    end
    stall = 0; halt_req = 0; jump = 1; lut_val = 4'd1;
    tick();
    compared++;
    if (pc !== 10'd16) begin
      mismatched++;
      $display("[TB] FAIL stallRelease pc=%0d exp 16", pc);
    end
    clearCtrl();
    tick();
    compared++;
    if (pc !== 10'd17) begin
      mismatched++;
      $display("[TB] FAIL afterStall pc=%0d exp 17", pc);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 1006; i++) tick();
    compared++;
    if (pc !== 10'd1023) begin
      mismatched++;
      $display("[TB] FAIL reachMax pc=%0d exp 1023", pc);
    end
    tick();
    compared++;
    if (pc !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL wrapUp pc=%0d exp 0", pc);
    end
    tick();
    branch_taken = 1; lut_val = 4'b1110;
    tick();
    compared++;
    if (pc !== 10'd1023) begin
      mismatched++;
      $display("[TB] FAIL wrapDown pc=%0d exp 1023", pc);
    end
    clearCtrl();
    tick();
  endtask

  task automatic test_halt();
    jump = 1; lut_val = 4'd7;
    tick();
    clearCtrl();
    halt_req = 1;
    tick();
    compared++;
    if ({running, done, pc} !== {1'b0, 1'b1, 10'd7}) begin
      mismatched++;
      $display("[TB] FAIL haltEntry run=%b done=%b pc=%0d exp run=0 done=1 pc=7", running, done, pc);
    end
    halt_req = 0; jump = 1; branch_taken = 1; lut_val = 4'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if ({running, done, pc} !== {1'b0, 1'b1, 10'd7}) begin
        mismatched++;
        $display("[TB] FAIL haltHold run=%b done=%b pc=%0d exp run=0 done=1 pc=7", running, done, pc);
      end
    end
    clearCtrl();
    start = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if ({running, done, pc} !== {1'b1, 1'b0, 10'(i)}) begin
        mismatched++;
        $display("[TB] FAIL startLevel run=%b done=%b pc=%0d exp run=1 done=0 pc=%0d", running, done, pc, i);
      end
    end
    start = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1;
    tick();
    compared++;
    if ({running, pc} !== {1'b1, 10'd0}) begin
      mismatched++;
      $display("[TB] FAIL restartInRun run=%b pc=%0d exp run=1 pc=0", running, pc);
    end
    start = 0;
    tick(); tick(); tick();
    reset = 1; jump = 1; lut_val = 4'd5;
    tick();
    compared++;
    if ({running, done, pc} !== {1'b0, 1'b0, 10'd0}) begin
      mismatched++;
      $display("[TB] FAIL resetMidRun run=%b done=%b pc=%0d exp run=0 done=0 pc=0", running, done, pc);
    end
    reset = 0;
    tick(); tick();
    compared++;
    if ({running, pc} !== {1'b0, 10'd0}) begin
      mismatched++;
      $display("[TB] FAIL idleIgnoresCtrl run=%b pc=%0d exp run=0 pc=0", running, pc);
    end
    clearCtrl();
    tick();
  endtask

`ifdef FETCH_PC_LINK_EN
  task automatic test_link();
    start = 1;
    tick();
    start = 0; jump = 1; lut_val = 4'd7;
    tick(); tick();
    lut_val = 4'd6;
    tick();
    compared++;
    if (pc !== 10'd20) begin
      mismatched++;
      $display("[TB] FAIL linkSetup pc=%0d exp 20", pc);
    end
    lut_val = 4'b1100;
    tick();
    compared++;
    if ({pc, link_pc} !== {10'd16, 10'd21}) begin
      mismatched++;
      $display("[TB] FAIL linkJump pc=%0d link=%0d exp pc=16 link=21", pc, link_pc);
    end
    jump = 0; branch_taken = 1; lut_val = 4'd0;
    tick();
    compared++;
    if ({pc, link_pc} !== {10'd16, 10'd21}) begin
      mismatched++;
      $display("[TB] FAIL linkBranch pc=%0d link=%0d exp pc=16 link=21", pc, link_pc);
    end
    clearCtrl();
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_branch();
    test_stall();
    test_wrap();
    test_halt();
    test_back_to_back();
`ifdef FETCH_PC_LINK_EN
    test_link();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
